// File: rtl/crp_collector.sv
// CRP collector: latches a challenge, races the arbiter, samples the response
// and streams LSB-first packed response bytes over valid/ready.
module crp_collector #(
    parameter int CHAL_W     = 1024,
    parameter int SETTLE_CYC = 16,
    parameter int NUM_CRP    = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CHAL_W-1:0] chal_in,
    output logic              chal_step,
    output logic [CHAL_W-1:0] puf_chal,
    output logic              puf_fire,
    input  logic              puf_resp,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       crp_count
);

    localparam int CNT_W = $clog2(SETTLE_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [15:0] CRP_LAST = 16'(NUM_CRP);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        CAPTURE,
        RELAX,
        EMIT,
        DONE
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       bit_idx_reg;
    logic [7:0]       pack_reg;
    logic [7:0]       pack_next;
    logic             resp_meta_reg;
    logic             resp_sync_reg;
    logic             pack_clr;
    logic             pack_wr;

    // The arbiter output is not related to clk, so it crosses through two flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_meta_reg <= 1'b0;
            resp_sync_reg <= 1'b0;
        end else begin
            resp_meta_reg <= puf_resp;
            resp_sync_reg <= resp_meta_reg;
        end
    end

    assign pack_clr = (((state_reg == IDLE) || (state_reg == DONE)) && start)
                    || ((state_reg == EMIT) && m_ready);
    assign pack_wr  = (state_reg == CAPTURE);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pack
            assign pack_next[gi] = pack_clr ? 1'b0 :
                                   (pack_wr && (bit_idx_reg == 4'(gi))) ? resp_sync_reg :
                                   pack_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pack_reg <= 8'h00;
        end else begin
            pack_reg <= pack_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= 4'd0;
            crp_count   <= 16'd0;
            puf_chal    <= '0;
            puf_fire    <= 1'b0;
            chal_step   <= 1'b0;
            m_data      <= 8'h00;
            m_valid     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            chal_step <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg   <= LOAD;
                        crp_count   <= 16'd0;
                        bit_idx_reg <= 4'd0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        chal_step   <= 1'b1;
                    end
                end
                LOAD: begin
                    puf_chal  <= chal_in;
                    puf_fire  <= 1'b1;
                    cnt_reg   <= SETTLE_LOAD;
                    state_reg <= FIRE;
                end
                FIRE: begin
                    if (cnt_reg == '0) begin
                        state_reg <= CAPTURE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                CAPTURE: begin
                    bit_idx_reg <= bit_idx_reg + 4'd1;
                    if (crp_count != CRP_LAST) begin
                        crp_count <= crp_count + 16'd1;
                    end
                    puf_fire  <= 1'b0;
                    cnt_reg   <= SETTLE_LOAD;
                    state_reg <= RELAX;
                end
                RELAX: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else if ((bit_idx_reg == 4'd8) || (crp_count == CRP_LAST)) begin
                        m_data    <= pack_reg;
                        m_valid   <= 1'b1;
                        state_reg <= EMIT;
                    end else begin
                        chal_step <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                EMIT: begin
                    // While stalled nothing advances, so m_data stays put.
                    if (m_ready) begin
                        m_valid     <= 1'b0;
                        bit_idx_reg <= 4'd0;
                        if (crp_count == CRP_LAST) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            chal_step <= 1'b1;
                            state_reg <= LOAD;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crp_collector.sv
// Directed bench for crp_collector: SETTLE_CYC=4, NUM_CRP=10, 64-bit challenges.
module tb_crp_collector;

    localparam int CHAL_W = 64;
    localparam logic [CHAL_W-1:0] PAT_A = 64'hDEAD_BEEF_0123_4567;
    localparam logic [CHAL_W-1:0] PAT_B = 64'h5A5A_1234_F0F0_9876;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CHAL_W-1:0] chal_in;
    logic              chal_step;
    logic [CHAL_W-1:0] puf_chal;
    logic              puf_fire;
    logic              puf_resp;
    logic [7:0]        m_data;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              done;
    logic [15:0]       crp_count;

    int n_cmp = 0;
    int n_bad = 0;

    int         chal_steps;
    int         fire_run;
    int         fire_min;
    int         fire_max;
    logic [7:0] byte_q[$];

    crp_collector #(.CHAL_W(CHAL_W), .SETTLE_CYC(4), .NUM_CRP(10)) dut (
        .clk(clk), .reset(reset), .start(start), .chal_in(chal_in),
        .chal_step(chal_step), .puf_chal(puf_chal), .puf_fire(puf_fire),
        .puf_resp(puf_resp), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy), .done(done), .crp_count(crp_count)
    );

    always #5 clk = ~clk;

    // Passive monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (chal_step) chal_steps++;
        if (m_valid && m_ready) byte_q.push_back(m_data);
        if (puf_fire) begin
            fire_run++;
        end else if (fire_run != 0) begin
            if (fire_run < fire_min) fire_min = fire_run;
            if (fire_run > fire_max) fire_max = fire_run;
            fire_run = 0;
        end
    end

    task automatic clear_mon();
        chal_steps = 0;
        fire_run   = 0;
        fire_min   = 999;
        fire_max   = 0;
        byte_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({busy, done, m_valid, puf_fire, chal_step} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000", {busy, done, m_valid, puf_fire, chal_step});
        end
        n_cmp++;
        if (puf_chal !== '0 || crp_count !== 16'd0 || m_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_data: chal=%h cnt=%0d data=%h want 0/0/0", puf_chal, crp_count, m_data);
        end
        @(posedge clk); #1 reset = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_pattern();
        bit   vec [10] = '{1, 0, 1, 1, 0, 0, 0, 1, 1, 1};
        logic c1, c2;
        bit   ok;
        clear_mon();
        puf_resp = vec[0];
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk); c1 = chal_step;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); c2 = chal_step;
        n_cmp++;
        if (c1 !== 1'b0 || c2 !== 1'b1) begin
            n_bad++;
            $display("FAIL start_latency: chal_step after 0/1 cycles = %b/%b want 0/1", c1, c2);
        end
        for (int i = 1; i < 10; i++) begin
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (chal_step) break;
            end
            puf_resp = vec[i];
        end
        wait_done(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL pattern_timeout: done never rose"); end
        n_cmp++;
        if (byte_q.size() !== 2) begin
            n_bad++;
            $display("FAIL pattern_bytes: got %0d bytes want 2", byte_q.size());
        end else begin
            n_cmp++;
            if (byte_q[0] !== 8'h8D || byte_q[1] !== 8'h03) begin
                n_bad++;
                $display("FAIL pattern_data: got %h %h want 8d 03", byte_q[0], byte_q[1]);
            end
        end
        n_cmp++;
        if (fire_min !== 5 || fire_max !== 5) begin
            n_bad++;
            $display("FAIL fire_width: min %0d max %0d want 5", fire_min, fire_max);
        end
        n_cmp++;
        if (chal_steps !== 10 || crp_count !== 16'd10 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL pattern_end: steps %0d cnt %0d busy %b want 10/10/0", chal_steps, crp_count, busy);
        end
        $display("test_pattern: bytes=%0d", byte_q.size());
    endtask

    task automatic test_all_ones();
        bit ok;
        clear_mon();
        puf_resp = 1'b1;
        pulse_start();
        wait_done(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL ones_timeout: done never rose"); end
        n_cmp++;
        if (byte_q.size() !== 2) begin
            n_bad++;
            $display("FAIL ones_handshakes: got %0d want 2", byte_q.size());
        end else begin
            n_cmp++;
            if (byte_q[0] !== 8'hFF || byte_q[1] !== 8'h03) begin
                n_bad++;
                $display("FAIL ones_data: got %h %h want ff 03", byte_q[0], byte_q[1]);
            end
        end
        n_cmp++;
        if (done !== 1'b1 || crp_count !== 16'd10) begin
            n_bad++;
            $display("FAIL ones_end: done %b cnt %0d want 1/10", done, crp_count);
        end
        $display("test_all_ones: bytes=%0d", byte_q.size());
    endtask

    task automatic test_stall();
        logic [7:0] hold;
        int         bad = 0;
        bit         seen = 1'b0;
        bit         ok;
        clear_mon();
        puf_resp = 1'b1;
        m_ready  = 1'b0;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL stall_valid: m_valid never rose"); end
        hold = m_data;
        n_cmp++;
        if (hold !== 8'hFF) begin
            n_bad++;
            $display("FAIL stall_byte: got %h want ff", hold);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_data !== hold || puf_fire !== 1'b0 || chal_step !== 1'b0 || m_valid !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL stall_hold: %0d bad cycles want 0", bad);
        end
        @(posedge clk); #1 m_ready = 1'b1;
        wait_done(ok);
        n_cmp++;
        if (!ok || byte_q.size() !== 2 || chal_steps !== 10) begin
            n_bad++;
            $display("FAIL stall_resume: done %b bytes %0d steps %0d want 1/2/10", ok, byte_q.size(), chal_steps);
        end
        $display("test_stall: bad_cycles=%0d", bad);
    endtask

    task automatic test_chal();
        int bad = 0;
        bit ok;
        bit seen = 1'b0;
        clear_mon();
        chal_in = PAT_A;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (puf_fire) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (!seen || puf_chal !== PAT_A) begin
            n_bad++;
            $display("FAIL chal_latch: got %h want %h", puf_chal, PAT_A);
        end
        chal_in = PAT_B;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!puf_fire) break;
            if (puf_chal !== PAT_A) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL chal_stable: %0d cycles changed want 0", bad);
        end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (puf_fire) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (!seen || puf_chal !== PAT_B) begin
            n_bad++;
            $display("FAIL chal_next: got %h want %h", puf_chal, PAT_B);
        end
        wait_done(ok);
        n_cmp++;
        if (!ok || puf_chal !== PAT_B) begin
            n_bad++;
            $display("FAIL chal_done_hold: done %b chal %h want 1/%h", ok, puf_chal, PAT_B);
        end
        $display("test_chal: puf_chal=%h", puf_chal);
    endtask

    task automatic test_abort();
        bit ok;
        bit hit = 1'b0;
        clear_mon();
        chal_in  = PAT_A;
        puf_resp = 1'b1;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (chal_steps == 5 && puf_fire) begin hit = 1'b1; break; end
        end
        n_cmp++;
        if (!hit) begin n_bad++; $display("FAIL abort_reach: never reached FIRE of CRP 5"); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, m_valid, puf_fire, chal_step} !== 5'b0) begin
            n_bad++;
            $display("FAIL abort_flags: got %b want 00000", {busy, done, m_valid, puf_fire, chal_step});
        end
        n_cmp++;
        if (puf_chal !== '0 || crp_count !== 16'd0) begin
            n_bad++;
            $display("FAIL abort_data: chal %h cnt %0d want 0/0", puf_chal, crp_count);
        end
        @(posedge clk); #1 reset = 1'b0;
        clear_mon();
        pulse_start();
        @(negedge clk);
        n_cmp++;
        if (crp_count !== 16'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_begin: cnt %0d busy %b want 0/1", crp_count, busy);
        end
        repeat (25) @(negedge clk);
        pulse_start();
        wait_done(ok);
        n_cmp++;
        if (!ok || crp_count !== 16'd10 || chal_steps !== 10 || byte_q.size() !== 2) begin
            n_bad++;
            $display("FAIL restart_full: done %b cnt %0d steps %0d bytes %0d want 1/10/10/2",
                     ok, crp_count, chal_steps, byte_q.size());
        end
        $display("test_abort: cnt=%0d steps=%0d", crp_count, chal_steps);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        chal_in  = '0;
        puf_resp = 1'b0;
        m_ready  = 1'b1;
        clear_mon();
        test_reset();
        test_pattern();
        test_all_ones();
        test_stall();
        test_chal();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
